// File: rtl/riscv_pkg.sv
// Shared RV32I integer-datapath types and sizes used by the register file slice.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   reg_addr_t;

  localparam reg_addr_t REG_ZERO = {AW{1'b0}};
  localparam word_t     WORD_ZERO = {XLEN{1'b0}};

  // x0 is architecturally constant, so every access path keys off this test
  function automatic logic is_x0(input reg_addr_t addr);
    return (addr == REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Decode/writeback-side bus of the integer register file: one write port, two read ports.
interface reg_file_if;
  import riscv_pkg::*;

  logic      w_en;
  reg_addr_t waddr;
  word_t     wdata;
  reg_addr_t raddr1;
  word_t     rdata1;
  reg_addr_t raddr2;
  word_t     rdata2;

  modport master (
    output w_en, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  w_en, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );

endinterface

// File: rtl/reg_file_rport.sv
// One combinational read port with x0 masking.
// Optional same-cycle write forwarding when REGS_BYPASS_EN is defined.
module reg_file_rport
  import riscv_pkg::*;
(
  input  word_t     regs [1:NREGS-1],
  input  reg_addr_t raddr,
`ifdef REGS_BYPASS_EN
  input  logic      w_en,
  input  reg_addr_t waddr,
  input  word_t     wdata,
`endif
  output word_t     rdata
);

  word_t rdata_s;

  // read mux: x0 masks to zero, otherwise committed (or forwarded) value
  always_comb begin
    rdata_s = WORD_ZERO;
    if (is_x0(raddr)) begin
      rdata_s = WORD_ZERO;
    end else begin
`ifdef REGS_BYPASS_EN
      if (w_en && !is_x0(waddr) && (waddr == raddr)) begin
        rdata_s = wdata;
      end else begin
        rdata_s = regs[raddr];
      end
`else
      rdata_s = regs[raddr];
`endif
    end
  end

  assign rdata = rdata_s;

endmodule

// File: rtl/reg_file.sv
// RV32I integer register file x0..x31: storage for x1..x31 plus two independent read ports.
// Build option: REGS_BYPASS_EN forwards the in-flight write to matching read ports.
module reg_file
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  bus
);

  // x0 has no storage; it is synthesised as a constant in each read port
  word_t regs_r [1:NREGS-1];

  // storage update: reset clears everything and wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_r[i] <= WORD_ZERO;
      end
    end else if (bus.w_en && !is_x0(bus.waddr)) begin
      regs_r[bus.waddr] <= bus.wdata;
    end
  end

  reg_file_rport u_rport1 (
    .regs  (regs_r),
    .raddr (bus.raddr1),
`ifdef REGS_BYPASS_EN
    .w_en  (bus.w_en),
    .waddr (bus.waddr),
    .wdata (bus.wdata),
`endif
    .rdata (bus.rdata1)
  );

  reg_file_rport u_rport2 (
    .regs  (regs_r),
    .raddr (bus.raddr2),
`ifdef REGS_BYPASS_EN
    .w_en  (bus.w_en),
    .waddr (bus.waddr),
    .wdata (bus.wdata),
`endif
    .rdata (bus.rdata2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: reference register array plus expected-value scoreboard.
module tb_reg_file;
  import riscv_pkg::*;

  logic clk;
  logic rst_n;
  reg_file_if rf_if ();

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks_cnt = 0;
  int    errors_cnt = 0;
  word_t model [0:NREGS-1];
  word_t sb_val [$];
  string sb_tag [$];

  task automatic check(input string tag, input word_t got, input word_t exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // expected read value given the reference array and what is currently driven
  function automatic word_t exp_read(input reg_addr_t a);
    if (a == 5'd0) return 32'd0;
`ifdef REGS_BYPASS_EN
    if (rf_if.w_en && rf_if.waddr != 5'd0 && rf_if.waddr == a) return rf_if.wdata;
`endif
    return model[a];
  endfunction

  task automatic read_check(input string t1, input reg_addr_t a1,
                            input string t2, input reg_addr_t a2);
    rf_if.raddr1 = a1;
    rf_if.raddr2 = a2;
    sb_val.push_back(exp_read(a1)); sb_tag.push_back(t1);
    sb_val.push_back(exp_read(a2)); sb_tag.push_back(t2);
    #1;
    check(sb_tag.pop_front(), rf_if.rdata1, sb_val.pop_front());
    check(sb_tag.pop_front(), rf_if.rdata2, sb_val.pop_front());
  endtask

  task automatic model_edge(input logic we, input reg_addr_t wa, input word_t wd);
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) model[i] = 32'd0;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
  endtask

  // one write cycle; reads of the target before the edge see old (or forwarded) data
  task automatic clk_edge(input logic we, input reg_addr_t wa, input word_t wd);
    @(negedge clk);
    rf_if.w_en  = we;
    rf_if.waddr = wa;
    rf_if.wdata = wd;
    read_check("pre_edge_p1", wa, "pre_edge_p2", wa);
    @(posedge clk);
    model_edge(we, wa, wd);
    #1;
    rf_if.w_en = 1'b0;
  endtask

  task automatic reset_edge(input logic we, input reg_addr_t wa, input word_t wd);
    @(negedge clk);
    rst_n       = 1'b0;
    rf_if.w_en  = we;
    rf_if.waddr = wa;
    rf_if.wdata = wd;
    @(posedge clk);
    model_edge(we, wa, wd);
    #1;
    rf_if.w_en = 1'b0;
    rst_n      = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) model[i] = 32'd0;
    rst_n        = 1'b0;
    rf_if.w_en   = 1'b0;
    rf_if.waddr  = 5'd0;
    rf_if.wdata  = 32'd0;
    rf_if.raddr1 = 5'd0;
    rf_if.raddr2 = 5'd0;
    #1;
    check("x0_before_reset_p1", rf_if.rdata1, 32'd0);
    check("x0_before_reset_p2", rf_if.rdata2, 32'd0);

    // reset with a competing write to x3: reset must win
    reset_edge(1'b1, 5'd3, 32'd55);
    reset_edge(1'b0, 5'd0, 32'd0);
    read_check("rst_x0_p1", 5'd0, "rst_x0_p2", 5'd0);
    read_check("rst_x31", 5'd31, "rst_x17", 5'd17);
    read_check("rst_prio_x3", 5'd3, "rst_x1", 5'd1);

    clk_edge(1'b0, 5'd1, 32'd1000);
    read_check("wen0_x1", 5'd1, "wen0_x0", 5'd0);
    clk_edge(1'b1, 5'd1, 32'd1000);
    read_check("wr_x1", 5'd1, "indep_x0", 5'd0);
    clk_edge(1'b1, 5'd0, 32'd1000);
    read_check("x0_immutable", 5'd0, "x1_kept", 5'd1);
    clk_edge(1'b0, 5'd1, 32'd2000);
    read_check("no_overwrite_x1", 5'd1, "no_overwrite_x31", 5'd31);
    clk_edge(1'b1, 5'd1, 32'd2000);
    read_check("overwrite_x1", 5'd1, "x1_p2", 5'd1);
    clk_edge(1'b1, 5'd31, 32'd2000);
    read_check("x1_after_x31", 5'd1, "wr_x31", 5'd31);
    clk_edge(1'b1, 5'd5, 32'd7);
    read_check("wr_x5_p1", 5'd5, "wr_x5_p2", 5'd5);

    for (int n = 0; n < 40; n++) begin
      reg_addr_t wa;
      reg_addr_t a1;
      reg_addr_t a2;
      wa = 5'($urandom_range(31, 0));
      a1 = 5'($urandom_range(31, 0));
      a2 = 5'($urandom_range(31, 0));
      clk_edge(1'($urandom_range(1, 0)), wa, 32'($urandom()));
      read_check("rand_p1", a1, "rand_p2", a2);
    end

    reset_edge(1'b0, 5'd0, 32'd0);
    read_check("post_rst_x1", 5'd1, "post_rst_x31", 5'd31);
    read_check("post_rst_x5", 5'd5, "post_rst_x0", 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
